// File: rtl/obi_rr_arbiter_if.sv
// Signal bundle between two OBI requesters (scalar S, vector V), the shared
// memory port and the round-robin arbiter.
interface obi_rr_arbiter_if;
   logic        s_req_i;
   logic        s_we_i;
   logic [3:0]  s_be_i;
   logic [31:0] s_addr_i;
   logic [31:0] s_wdata_i;
   logic        s_gnt_o;
   logic        s_rvalid_o;
   logic        s_err_o;
   logic [31:0] s_rdata_o;

   logic        v_req_i;
   logic        v_we_i;
   logic [3:0]  v_be_i;
   logic [31:0] v_addr_i;
   logic [31:0] v_wdata_i;
   logic        v_gnt_o;
   logic        v_rvalid_o;
   logic        v_err_o;
   logic [31:0] v_rdata_o;

   logic        data_req_o;
   logic        data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_addr_o;
   logic [31:0] data_wdata_o;
   logic        data_gnt_i;
   logic        data_rvalid_i;
   logic        data_err_i;
   logic [31:0] data_rdata_i;

   logic        protocol_err_o;
   logic [31:0] contention_cnt_o;

   // Arbiter side.
   modport slave (
      input  s_req_i, s_we_i, s_be_i, s_addr_i, s_wdata_i,
      input  v_req_i, v_we_i, v_be_i, v_addr_i, v_wdata_i,
      input  data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i,
      output s_gnt_o, s_rvalid_o, s_err_o, s_rdata_o,
      output v_gnt_o, v_rvalid_o, v_err_o, v_rdata_o,
      output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
      output protocol_err_o, contention_cnt_o
   );

   // Requesters plus memory side, i.e. whoever drives the arbiter.
   modport master (
      output s_req_i, s_we_i, s_be_i, s_addr_i, s_wdata_i,
      output v_req_i, v_we_i, v_be_i, v_addr_i, v_wdata_i,
      output data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i,
      input  s_gnt_o, s_rvalid_o, s_err_o, s_rdata_o,
      input  v_gnt_o, v_rvalid_o, v_err_o, v_rdata_o,
      input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
      input  protocol_err_o, contention_cnt_o
   );
endinterface

// File: rtl/obi_rr_arbiter.sv
// Two-requester OBI round-robin arbiter with an outstanding-ID FIFO for response routing.
// Define OBI_RR_ARBITER_PERF_EN to build the saturating contention counter.
module obi_rr_arbiter #(
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   obi_rr_arbiter_if.slave bus
);

   localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);
   localparam logic [CntW-1:0] FullCnt = CntW'(MaxOutstanding);

   typedef enum logic {
      SelS = 1'b0,
      SelV = 1'b1
   } sel_e;

   sel_e            sel;
   sel_e            prio_q, prio_d;
   sel_e            lockSel_q, lockSel_d;
   logic            lock_q, lock_d;
   logic [PtrW-1:0] wrPtr_q, wrPtr_d;
   logic [PtrW-1:0] rdPtr_q, rdPtr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            protErr_q, protErr_d;
   sel_e            fifo_q [MaxOutstanding];

   logic selReq;
   logic full;
   logic empty;
   logic reqOut;
   logic accept;
   logic pop;
   sel_e head;

   // A stalled address phase keeps its requester until the memory accepts it.
   always_comb begin
      sel = SelS;
      if (lock_q) begin
         sel = lockSel_q;
      end else if (bus.s_req_i && bus.v_req_i) begin
         sel = prio_q;
      end else if (bus.v_req_i) begin
         sel = SelV;
      end
   end

   assign selReq = (sel == SelV) ? bus.v_req_i : bus.s_req_i;
   assign full   = (cnt_q == FullCnt);
   assign empty  = (cnt_q == '0);
   assign reqOut = selReq && !full && !rst_i;
   assign accept = reqOut && bus.data_gnt_i;
   assign pop    = bus.data_rvalid_i && !empty && !rst_i;
   assign head   = fifo_q[rdPtr_q];

   assign bus.data_req_o   = reqOut;
   assign bus.data_we_o    = (sel == SelV) ? bus.v_we_i    : bus.s_we_i;
   assign bus.data_be_o    = (sel == SelV) ? bus.v_be_i    : bus.s_be_i;
   assign bus.data_addr_o  = (sel == SelV) ? bus.v_addr_i  : bus.s_addr_i;
   assign bus.data_wdata_o = (sel == SelV) ? bus.v_wdata_i : bus.s_wdata_i;

   assign bus.s_gnt_o    = accept && (sel == SelS);
   assign bus.v_gnt_o    = accept && (sel == SelV);
   assign bus.s_rvalid_o = pop && (head == SelS);
   assign bus.v_rvalid_o = pop && (head == SelV);
   assign bus.s_err_o    = bus.s_rvalid_o && bus.data_err_i;
   assign bus.v_err_o    = bus.v_rvalid_o && bus.data_err_i;
   assign bus.s_rdata_o  = bus.data_rdata_i;
   assign bus.v_rdata_o  = bus.data_rdata_i;

   assign bus.protocol_err_o = protErr_q;

   always_comb begin
      prio_d    = prio_q;
      lock_d    = lock_q;
      lockSel_d = lockSel_q;
      wrPtr_d   = wrPtr_q;
      rdPtr_d   = rdPtr_q;
      cnt_d     = cnt_q;
      protErr_d = protErr_q;
      if (accept) begin
         prio_d  = (sel == SelS) ? SelV : SelS;
         lock_d  = 1'b0;
         wrPtr_d = (wrPtr_q == LastPtr) ? '0 : wrPtr_q + PtrW'(1);
      end else if (reqOut) begin
         lock_d    = 1'b1;
         lockSel_d = sel;
      end else if (!selReq) begin
         lock_d = 1'b0;
      end
      if (pop) begin
         rdPtr_d = (rdPtr_q == LastPtr) ? '0 : rdPtr_q + PtrW'(1);
      end
      case ({accept, pop})
         2'b10:   cnt_d = cnt_q + CntW'(1);
         2'b01:   cnt_d = cnt_q - CntW'(1);
         default: cnt_d = cnt_q;
      endcase
      // A response with nothing outstanding is dropped and flagged until reset.
      if (bus.data_rvalid_i && empty) begin
         protErr_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prio_q    <= SelS;
         lock_q    <= 1'b0;
         lockSel_q <= SelS;
         wrPtr_q   <= '0;
         rdPtr_q   <= '0;
         cnt_q     <= '0;
         protErr_q <= 1'b0;
         for (int i = 0; i < int'(MaxOutstanding); i++) begin
            fifo_q[i] <= SelS;
         end
      end else begin
         prio_q    <= prio_d;
         lock_q    <= lock_d;
         lockSel_q <= lockSel_d;
         wrPtr_q   <= wrPtr_d;
         rdPtr_q   <= rdPtr_d;
         cnt_q     <= cnt_d;
         protErr_q <= protErr_d;
         if (accept) begin
            fifo_q[wrPtr_q] <= sel;
         end
      end
   end

`ifdef OBI_RR_ARBITER_PERF_EN
   logic [31:0] contCnt_q;

   // Both requesting means one of them necessarily waits this cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         contCnt_q <= '0;
      end else if (bus.s_req_i && bus.v_req_i && (contCnt_q != '1)) begin
         contCnt_q <= contCnt_q + 32'd1;
      end
   end

   assign bus.contention_cnt_o = contCnt_q;
`else
   assign bus.contention_cnt_o = '0;
`endif

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Scoreboard bench for obi_rr_arbiter: directed vectors queue expected grants and
// responses, a negedge monitor pops and compares them when the DUT presents them.
module tb_obi_rr_arbiter;

   typedef struct packed {
      logic        isV;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } gntExp_t;

   typedef struct packed {
      logic        isV;
      logic        err;
      logic [31:0] rdata;
   } rspExp_t;

   logic clock = 1'b0;
   logic reset;
   int   checkCount = 0;
   int   errorCount = 0;
   int   expCont = 0;

   gntExp_t gntQ [$];
   rspExp_t rspQ [$];
   gntExp_t gExp;
   rspExp_t rExp;

   always #5 clock = ~clock;

   obi_rr_arbiter_if bus ();

   obi_rr_arbiter #(.MaxOutstanding(2)) dut (
      .clk_i (clock),
      .rst_i (reset),
      .bus   (bus.slave)
   );

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic logic [31:0] expContValue();
`ifdef OBI_RR_ARBITER_PERF_EN
      return 32'(expCont);
`else
      return 32'd0;
`endif
   endfunction

   task automatic driveInputs(input logic sReq, input logic vReq,
                              input logic [31:0] sAddr, input logic [31:0] vAddr,
                              input logic gnt, input logic rv, input logic er,
                              input logic [31:0] rd);
      bus.s_req_i       = sReq;
      bus.s_we_i        = 1'b1;
      bus.s_be_i        = 4'hF;
      bus.s_addr_i      = sAddr;
      bus.s_wdata_i     = sAddr ^ 32'hA5A5_0000;
      bus.v_req_i       = vReq;
      bus.v_we_i        = 1'b0;
      bus.v_be_i        = 4'h3;
      bus.v_addr_i      = vAddr;
      bus.v_wdata_i     = vAddr ^ 32'h5A5A_0000;
      bus.data_gnt_i    = gnt;
      bus.data_rvalid_i = rv;
      bus.data_err_i    = er;
      bus.data_rdata_i  = rd;
   endtask

   task automatic idle();
      driveInputs(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   // expG / expR: 0 = none expected, 1 = scalar, 2 = vector.
   task automatic applyStimulus(input logic sReq, input logic vReq,
                                input logic [31:0] sAddr, input logic [31:0] vAddr,
                                input logic gnt, input logic rv, input logic er,
                                input logic [31:0] rd, input int expG, input int expR);
      driveInputs(sReq, vReq, sAddr, vAddr, gnt, rv, er, rd);
      if (expG == 1) gntQ.push_back('{isV: 1'b0, we: 1'b1, be: 4'hF, addr: sAddr, wdata: sAddr ^ 32'hA5A5_0000});
      if (expG == 2) gntQ.push_back('{isV: 1'b1, we: 1'b0, be: 4'h3, addr: vAddr, wdata: vAddr ^ 32'h5A5A_0000});
      if (expR != 0) rspQ.push_back('{isV: (expR == 2), err: er, rdata: rd});
      if (sReq && vReq) expCont++;
      #1;
   endtask

   task automatic nextCycle();
      @(posedge clock);
      #1;
   endtask

   // Monitor: compares whatever the DUT presents against the head of each queue.
   always @(negedge clock) begin
      if (bus.s_gnt_o || bus.v_gnt_o) begin
         if (gntQ.size() == 0) begin
            checkOutput("unexpectedGrant", {30'd0, bus.v_gnt_o, bus.s_gnt_o}, 32'd0);
         end else begin
            gExp = gntQ.pop_front();
            checkOutput("grantS", 32'(bus.s_gnt_o), 32'(!gExp.isV));
            checkOutput("grantV", 32'(bus.v_gnt_o), 32'(gExp.isV));
            checkOutput("grantAddr", bus.data_addr_o, gExp.addr);
            checkOutput("grantWdata", bus.data_wdata_o, gExp.wdata);
            checkOutput("grantWeBe", {27'd0, bus.data_we_o, bus.data_be_o}, {27'd0, gExp.we, gExp.be});
         end
      end
      if (bus.s_rvalid_o || bus.v_rvalid_o) begin
         if (rspQ.size() == 0) begin
            checkOutput("unexpectedRvalid", {30'd0, bus.v_rvalid_o, bus.s_rvalid_o}, 32'd0);
         end else begin
            rExp = rspQ.pop_front();
            checkOutput("rvalidS", 32'(bus.s_rvalid_o), 32'(!rExp.isV));
            checkOutput("rvalidV", 32'(bus.v_rvalid_o), 32'(rExp.isV));
            checkOutput("rspErr", {30'd0, bus.v_err_o, bus.s_err_o},
                        rExp.isV ? {30'd0, rExp.err, 1'b0} : {31'd0, rExp.err});
            checkOutput("rspRdata", rExp.isV ? bus.v_rdata_o : bus.s_rdata_o, rExp.rdata);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset with requests, grant and rvalid all high: nothing may leak out.
      reset = 1'b1;
      expCont = 0;
      driveInputs(1'b1, 1'b1, 32'h1000, 32'h2000, 1'b1, 1'b1, 1'b0, 32'h0);
      #2;
      checkOutput("resetDataReq", 32'(bus.data_req_o), 32'd0);
      checkOutput("resetGnt", {30'd0, bus.v_gnt_o, bus.s_gnt_o}, 32'd0);
      checkOutput("resetRvalid", {30'd0, bus.v_rvalid_o, bus.s_rvalid_o}, 32'd0);
      checkOutput("resetProtErr", 32'(bus.protocol_err_o), 32'd0);
      checkOutput("resetContention", bus.contention_cnt_o, 32'd0);
      idle();
      nextCycle();
      reset = 1'b0;

      $display("[TB] round-robin with both requesting");
      applyStimulus(1, 1, 32'h1000, 32'h2000, 1, 0, 0, 32'h00, 1, 0);
      checkOutput("rrDataReq", 32'(bus.data_req_o), 32'd1);
      nextCycle();
      applyStimulus(1, 1, 32'h1004, 32'h2004, 1, 1, 0, 32'h11, 2, 1);
      nextCycle();
      applyStimulus(1, 1, 32'h1008, 32'h2008, 1, 1, 0, 32'h22, 1, 2);
      nextCycle();
      applyStimulus(1, 1, 32'h100C, 32'h200C, 1, 1, 0, 32'h33, 2, 1);
      nextCycle();
      applyStimulus(0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h44, 0, 2);
      checkOutput("rrContention", bus.contention_cnt_o, expContValue());
      nextCycle();

      $display("[TB] address-phase lock under stalled grant");
      applyStimulus(0, 1, 32'h0, 32'h100, 0, 0, 0, 32'h0, 0, 0);
      checkOutput("lockAddr1", bus.data_addr_o, 32'h100);
      nextCycle();
      applyStimulus(1, 1, 32'h200, 32'h100, 0, 0, 0, 32'h0, 0, 0);
      checkOutput("lockAddr2", bus.data_addr_o, 32'h100);
      nextCycle();
      applyStimulus(1, 1, 32'h200, 32'h100, 0, 0, 0, 32'h0, 0, 0);
      checkOutput("lockAddr3", bus.data_addr_o, 32'h100);
      nextCycle();
      applyStimulus(1, 1, 32'h200, 32'h100, 1, 0, 0, 32'h0, 2, 0);
      checkOutput("lockAddr4", bus.data_addr_o, 32'h100);
      nextCycle();
      applyStimulus(1, 1, 32'h200, 32'h104, 1, 0, 0, 32'h0, 1, 0);
      checkOutput("lockNextAddr", bus.data_addr_o, 32'h200);
      nextCycle();
      applyStimulus(0, 0, 32'h0, 32'h0, 0, 1, 0, 32'h55, 0, 2);
      checkOutput("lockContention", bus.contention_cnt_o, expContValue());
      nextCycle();
      applyStimulus(0, 0, 32'h0, 32'h0, 0, 1, 0, 32'h66, 0, 1);
      nextCycle();

      $display("[TB] full outstanding FIFO blocks");
      applyStimulus(1, 0, 32'h300, 32'h0, 1, 0, 0, 32'h0, 1, 0);
      nextCycle();
      applyStimulus(1, 0, 32'h304, 32'h0, 1, 0, 0, 32'h0, 1, 0);
      nextCycle();
      applyStimulus(1, 0, 32'h308, 32'h0, 1, 0, 0, 32'h0, 0, 0);
      checkOutput("fullBlocked", 32'(bus.data_req_o), 32'd0);
      nextCycle();
      applyStimulus(1, 0, 32'h308, 32'h0, 1, 1, 0, 32'h77, 0, 1);
      checkOutput("fullBlockedOnPop", 32'(bus.data_req_o), 32'd0);
      nextCycle();
      applyStimulus(1, 0, 32'h308, 32'h0, 1, 0, 0, 32'h0, 1, 0);
      checkOutput("fullReleased", 32'(bus.data_req_o), 32'd1);
      nextCycle();
      applyStimulus(0, 0, 32'h0, 32'h0, 0, 1, 0, 32'h88, 0, 1);
      nextCycle();
      applyStimulus(0, 0, 32'h0, 32'h0, 0, 1, 0, 32'h99, 0, 1);
      nextCycle();

      $display("[TB] error response routing");
      applyStimulus(0, 1, 32'h0, 32'h400, 1, 0, 0, 32'h0, 2, 0);
      nextCycle();
      applyStimulus(1, 0, 32'h500, 32'h0, 1, 0, 0, 32'h0, 1, 0);
      nextCycle();
      applyStimulus(0, 0, 32'h0, 32'h0, 0, 1, 1, 32'hAA, 0, 2);
      checkOutput("errVectorErr", 32'(bus.v_err_o), 32'd1);
      nextCycle();
      applyStimulus(0, 0, 32'h0, 32'h0, 0, 1, 0, 32'hBB, 0, 1);
      checkOutput("errScalarOk", {30'd0, bus.s_err_o, bus.s_rvalid_o}, 32'h1);
      nextCycle();

      $display("[TB] stray rvalid after reset");
      reset = 1'b1;
      expCont = 0;
      idle();
      nextCycle();
      reset = 1'b0;
      applyStimulus(0, 0, 32'h0, 32'h0, 0, 1, 0, 32'hC0, 0, 0);
      checkOutput("strayNoRvalid", {30'd0, bus.v_rvalid_o, bus.s_rvalid_o}, 32'd0);
      nextCycle();
      applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, 0);
      checkOutput("strayProtErr1", 32'(bus.protocol_err_o), 32'd1);
      nextCycle();
      nextCycle();
      checkOutput("strayProtErrSticky", 32'(bus.protocol_err_o), 32'd1);
      reset = 1'b1;
      expCont = 0;
      #1;
      checkOutput("strayProtErrCleared", 32'(bus.protocol_err_o), 32'd0);
      nextCycle();
      reset = 1'b0;

      $display("[TB] reset with outstanding transactions");
      applyStimulus(0, 1, 32'h0, 32'h600, 1, 0, 0, 32'h0, 2, 0);
      nextCycle();
      applyStimulus(1, 0, 32'h700, 32'h0, 1, 0, 0, 32'h0, 1, 0);
      nextCycle();
      driveInputs(1'b1, 1'b1, 32'h704, 32'h604, 1'b1, 1'b1, 1'b0, 32'hEE);
      #1;
      reset = 1'b1;
      expCont = 0;
      #1;
      checkOutput("asyncDataReq", 32'(bus.data_req_o), 32'd0);
      checkOutput("asyncGnt", {30'd0, bus.v_gnt_o, bus.s_gnt_o}, 32'd0);
      checkOutput("asyncRvalid", {30'd0, bus.v_rvalid_o, bus.s_rvalid_o}, 32'd0);
      checkOutput("asyncContention", bus.contention_cnt_o, 32'd0);
      @(posedge clock);
      #1;
      idle();
      reset = 1'b0;
      applyStimulus(0, 0, 32'h0, 32'h0, 0, 1, 0, 32'hCC, 0, 0);
      nextCycle();
      applyStimulus(1, 1, 32'h800, 32'h900, 1, 0, 0, 32'h0, 1, 0);
      checkOutput("postResetProtErr", 32'(bus.protocol_err_o), 32'd1);
      checkOutput("postResetPrioAddr", bus.data_addr_o, 32'h800);
      nextCycle();
      applyStimulus(0, 0, 32'h0, 32'h0, 0, 1, 0, 32'hDD, 0, 1);
      checkOutput("postResetContention", bus.contention_cnt_o, expContValue());
      nextCycle();
      idle();
      nextCycle();

      checkOutput("grantQueueEmpty", 32'(gntQ.size()), 32'd0);
      checkOutput("rspQueueEmpty", 32'(rspQ.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
